// File: rtl/act_table_scheduler.sv
// Round-robin scheduler that shares one LANES-wide activation table bank between two
// requesters: streams the granted vector chunk by chunk and rebuilds the result in q.
module act_table_scheduler #(
  parameter int DATA_LEN = 8,
  parameter int LANES    = 12,
  parameter int CHUNKS   = 32,
  parameter int LAT      = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load0,
  input  logic [CHUNKS*LANES*DATA_LEN-1:0] d0,
  output logic                             valid0,
  input  logic                             load1,
  input  logic [CHUNKS*LANES*DATA_LEN-1:0] d1,
  output logic                             valid1,
  output logic [1:0]                       grant,
  output logic [CHUNKS*LANES*DATA_LEN-1:0] q,
  output logic [LANES*DATA_LEN-1:0]        tbl_d,
  input  logic [LANES*DATA_LEN-1:0]        tbl_q
);

  localparam int CW    = LANES * DATA_LEN;
  localparam int VW    = CHUNKS * CW;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             prio_q, prio_d;   // requester that wins when both load together
  logic [IDX_W-1:0] idx_q, idx_d;
  tag_t [LAT-1:0]   tag_q;
  logic [CW-1:0]    tbl_d_q;
  logic [VW-1:0]    q_q;

  logic          owner_load;
  logic          issue;
  logic          flush;
  logic          tags_busy;
  logic [VW-1:0] owner_vec;
  tag_t          tag_out;

  assign owner_load = (grant_q[0] & load0) | (grant_q[1] & load1);
  assign owner_vec  = grant_q[1] ? d1 : d0;
  assign issue      = (state_q == S_ISSUE) && owner_load;
  assign flush      = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && !owner_load;
  assign tag_out    = tag_q[LAT-1];

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < LAT; i++) tags_busy = tags_busy | tag_q[i].vld;
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    // NOTE: every combinationally written variable gets a default first, so no latch is inferred.
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (load0 || load1) begin
          state_d = S_ISSUE;
          if (load0 && load1) grant_d = prio_q ? 2'b10 : 2'b01;
          else                grant_d = load1  ? 2'b10 : 2'b01;
        end
      end
      S_ISSUE: begin
        if (idx_q == LAST_IDX) state_d = S_DRAIN;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_DRAIN: if (!tags_busy) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    // Owner dropping its load ends the transaction (normal exit or abort) and hands priority over.
    if ((state_q != S_IDLE) && !owner_load) begin
      state_d = S_IDLE;
      grant_d = 2'b00;
      prio_d  = grant_q[0];
      idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      tag_q   <= '0;
      tbl_d_q <= '0;
      // NOTE: q is an output result buffer with a defined reset value, so it is reset like any
      // other register rather than left as uninitialised storage.
      q_q     <= '0;
    end else begin
      idx_q <= idx_d;
      if (issue) tbl_d_q <= owner_vec[int'(idx_q)*CW +: CW];
      tag_q[0] <= flush ? tag_t'('0) : tag_t'{vld: issue, idx: idx_q};
      for (int i = 1; i < LAT; i++) tag_q[i] <= flush ? tag_t'('0) : tag_q[i-1];
      if (tag_out.vld && !flush) q_q[int'(tag_out.idx)*CW +: CW] <= tbl_q;
    end
  end

  always_comb begin
    valid0 = (state_q == S_DONE) && grant_q[0];
    valid1 = (state_q == S_DONE) && grant_q[1];
    grant  = grant_q;
    tbl_d  = tbl_d_q;
    q      = q_q;
  end

endmodule
